// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the 2-to-4 hold decoder slice.
//   ONEHOT_W : width of the one-hot decode (4)
//   CODE_W   : width of the binary code feeding the decoder (2)
//   state_t  : controller states IDLE / DRIVE
// Optional feature macro used by this slice: DEC2X4_PARITY_EN
// -----------------------------------------------------------------------------
package dec_pkg;

   localparam int ONEHOT_W = 4;
   localparam int CODE_W   = 2;

   // IDLE: nothing displayed, always ready.
   // DRIVE: a decode is being held on y for a fixed number of cycles.
   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/decoder_2x4_core.sv
// -----------------------------------------------------------------------------
// decoder_2x4_core
// Purely combinational 2-bit binary to 4-bit one-hot decoder.
// Ports:
//   code   [CODE_W-1:0]   in  : binary code 0..3
//   onehot [ONEHOT_W-1:0] out : exactly one bit set, bit index = code
// -----------------------------------------------------------------------------
module decoder_2x4_core
   import dec_pkg::*;
(
   input  logic [CODE_W-1:0]   code,
   output logic [ONEHOT_W-1:0] onehot
);

   // Every code value maps to exactly one set bit, so the default arm only
   // exists to keep the block free of latches.
   always_comb begin
      onehot = '0;
      case (code)
         2'd0:    onehot = 4'b0001;
         2'd1:    onehot = 4'b0010;
         2'd2:    onehot = 4'b0100;
         2'd3:    onehot = 4'b1000;
         default: onehot = '0;
      endcase
   end

endmodule

// File: rtl/decoder_2x4_hold.sv
// -----------------------------------------------------------------------------
// decoder_2x4_hold
// Accepts a 2-bit code through a valid/ready handshake and presents its
// registered one-hot decode on y for HOLD_CYCLES cycles. A new code can be
// accepted on the last hold cycle so back-to-back codes leave no idle gap.
//
// Parameters:
//   HOLD_CYCLES : cycles each decode is held, 1..255
// Ports:
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset
//   in_valid  in  : a code is offered
//   in_ready  out : a code can be accepted this cycle
//   in_code   in  : binary code 0..3
//   in_par    in  : even parity over in_code   (DEC2X4_PARITY_EN only)
//   y         out : registered one-hot decode, 0 when idle
//   y_valid   out : y holds a live decode
//   err       out : one-cycle parity error pulse (DEC2X4_PARITY_EN only)
//
// Build option: define DEC2X4_PARITY_EN to add the parity check; codes with
// bad parity complete the handshake but are not displayed.
// -----------------------------------------------------------------------------
module decoder_2x4_hold
   import dec_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CODE_W-1:0]   in_code,
`ifdef DEC2X4_PARITY_EN
   input  logic                in_par,
`endif
   output logic [ONEHOT_W-1:0] y,
   output logic                y_valid
`ifdef DEC2X4_PARITY_EN
   ,
   output logic                err
`endif
);

   // The counter holds the number of hold cycles still to come after the
   // current one, so 0 marks the last hold cycle.
   localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t                state;
   state_t                state_next;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic [ONEHOT_W-1:0]   dec_code;
   logic [ONEHOT_W-1:0]   y_next;
   logic                  y_valid_next;
   logic                  accept;
   logic                  code_ok;
`ifdef DEC2X4_PARITY_EN
   logic                  err_next;
`endif

   decoder_2x4_core u_core (
      .code   (in_code),
      .onehot (dec_code)
   );

   // Ready whenever nothing is displayed, or on the final hold cycle so the
   // next code can replace the current one without a gap.
   assign in_ready = (state == IDLE) || (cnt == '0);
   assign accept   = in_valid && in_ready;

`ifdef DEC2X4_PARITY_EN
   // Even parity: in_par together with the code must XOR to zero.
   assign code_ok = ~(^{in_par, in_code});
`else
   assign code_ok = 1'b1;
`endif

   // State register plus the registered outputs. Reset clears everything
   // immediately so an interrupted hold leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         y       <= '0;
         y_valid <= 1'b0;
`ifdef DEC2X4_PARITY_EN
         err     <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         y       <= y_next;
         y_valid <= y_valid_next;
`ifdef DEC2X4_PARITY_EN
         err     <= err_next;
`endif
      end
   end

   // Next-state logic. An acceptance always wins: a good code (re)starts the
   // hold, a rejected code drops straight back to IDLE. Otherwise DRIVE
   // counts down and leaves once the last hold cycle has passed.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (accept) begin
         if (code_ok) begin
            state_next = DRIVE;
            cnt_next   = CNT_LOAD;
         end else begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      end else if (state == DRIVE) begin
         if (cnt != '0) begin
            cnt_next = cnt - 1'b1;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // Output logic: the values y/y_valid/err take on the next edge. y only
   // ever receives the core's one-hot word or zero, so at most one bit is
   // ever set and y_valid tracks whether that word is live.
   always_comb begin
      y_next       = y;
      y_valid_next = y_valid;
      if (accept) begin
         if (code_ok) begin
            y_next       = dec_code;
            y_valid_next = 1'b1;
         end else begin
            y_next       = '0;
            y_valid_next = 1'b0;
         end
      end else if ((state == DRIVE) && (cnt == '0)) begin
         y_next       = '0;
         y_valid_next = 1'b0;
      end
`ifdef DEC2X4_PARITY_EN
      err_next = accept && !code_ok;
`endif
   end

endmodule

// File: doc/decoder_2x4_hold.md
DECODER_2X4_HOLD -- requirements
Module: decoder_2x4_hold

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning the number of cycles each decoded one-hot output is held (legal range 1..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, width 1: a code is offered.
REQ-004 SHALL have port in_ready, output, width 1: the block can accept a code this cycle.
REQ-005 SHALL have port in_code, input, width 2: binary code, 0..3.
REQ-006 SHALL have port in_par, input, width 1: even-parity bit over in_code (present only with DEC2X4_PARITY_EN).
REQ-007 SHALL have port y, output, width 4: registered one-hot decode, 4'b0000 when idle.
REQ-008 SHALL have port y_valid, output, width 1: y holds a live decode.
REQ-009 SHALL have port err, output, width 1: one-cycle parity-error pulse (present only with DEC2X4_PARITY_EN).

Function
REQ-010 SHALL implement FSM states IDLE and DRIVE, plus a hold counter of width clog2(HOLD_CYCLES+1).
REQ-011 SHALL assert in_ready in IDLE, and in DRIVE when the counter equals 0 (last hold cycle); otherwise in_ready SHALL be 0.
REQ-012 SHALL accept a code when in_valid and in_ready are both 1 on a rising clk; in_code SHALL be sampled only then.
REQ-013 SHALL, on acceptance, drive y = 1 << in_code and y_valid = 1 from the next cycle, with the counter loaded to HOLD_CYCLES-1 and state DRIVE (latency 1).
REQ-014 SHALL decrement the counter each cycle in DRIVE while it is nonzero; y and y_valid SHALL remain stable for exactly HOLD_CYCLES cycles.
REQ-015 SHALL, in DRIVE with counter 0 and no acceptance, go to IDLE with y = 4'b0000 and y_valid = 0 next cycle.
REQ-016 SHALL, in DRIVE with counter 0 and acceptance (back-to-back), load the new decode and counter with no idle gap cycle.
REQ-017 SHALL, with HOLD_CYCLES = 1, keep in_ready = 1 continuously and pass one code per cycle.
REQ-018 SHALL never present y with more than one bit set; y_valid = 1 SHALL imply y is nonzero.
REQ-019 SHALL ignore in_valid when in_ready = 0; the upstream holds its code, and no code is dropped or duplicated.

Reset
REQ-020 SHALL, while rst_n = 0, immediately force state IDLE, counter 0, y = 4'b0000, y_valid = 0, err = 0; in_ready SHALL be 1 after the first clk edge following rst_n release.
REQ-021 SHALL, on reset asserted mid-DRIVE, abort the hold at once with no residual output after release.

Configuration
REQ-022 SHALL, when macro DEC2X4_PARITY_EN is defined, include ports in_par and err; an accepted code with ^{in_par,in_code} = 1 SHALL still complete the handshake but SHALL NOT enter DRIVE (y stays 0, or goes 0 if this was a back-to-back accept), and err SHALL pulse 1 for exactly one cycle, one cycle after acceptance.
REQ-023 SHALL, without DEC2X4_PARITY_EN, omit in_par and err and decode every accepted code.

Structure
REQ-024 SHALL place the state enum (IDLE, DRIVE) and the one-hot width constant (4) in shared package dec_pkg.
REQ-025 SHALL instantiate a combinational sub-module decoder_2x4_core (2-bit code -> 4-bit one-hot), reused wherever one-hot decode is needed.

Verification
REQ-026 SHALL cover: HOLD_CYCLES=4, single code 2'b10 -> y=4'b0100 and y_valid=1 for exactly 4 cycles starting 1 cycle after accept, then y=0.
REQ-027 SHALL cover: HOLD_CYCLES=3, codes 0 then 3 with in_valid held high -> y=0001 for 3 cycles, then 1000 for 3 cycles, no gap; in_ready high only on cycles 0 and 3.
REQ-028 SHALL cover: HOLD_CYCLES=1, codes 0,1,2,3 on consecutive cycles -> y = 0001, 0010, 0100, 1000 on consecutive cycles.
REQ-029 SHALL cover: rst_n pulled low on cycle 2 of a 4-cycle hold -> y=0 and y_valid=0 immediately, asynchronously; after release, code 1 -> y=0010.
REQ-030 SHALL cover (DEC2X4_PARITY_EN): in_code=2'b01 with in_par=0 -> err=1 for one cycle and y stays 0; the same code with in_par=1 -> y=0010.
REQ-031 SHALL cover: in_valid asserted while in_ready=0 with a changing in_code -> no acceptance, and the first code presented when in_ready=1 is the one decoded.
